// File: rtl/tf328_pkg.sv
// TF328 shared definitions: AutoConfig register offsets, FSM state types,
// and the Zorro II size-code helper used by the identity ROM.
package tf328_pkg;

  localparam logic [6:0] REG_TYPE    = 7'h00;
  localparam logic [6:0] REG_PROD    = 7'h04;
  localparam logic [6:0] REG_FLAGS   = 7'h08;
  localparam logic [6:0] REG_MANUF   = 7'h10;
  localparam logic [6:0] REG_SERIAL  = 7'h18;
  localparam logic [6:0] REG_BASE_HI = 7'h48;
  localparam logic [6:0] REG_BASE_LO = 7'h4A;
  localparam logic [6:0] REG_SHUTUP  = 7'h4C;

  typedef enum logic [1:0] {UNCFG, CONFIGURED, SHUTUP} cfg_state_t;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} cyc_state_t;

  // Zorro II size field: 2MB = 110, 4MB = 111, 8MB = 000
  function automatic logic [2:0] size_code(input int size_mb);
    case (size_mb)
      2:       return 3'b110;
      4:       return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/z2_autoconfig_if.sv
// CPU-side bus bundle between the 68020 bus logic and the AutoConfig
// responder. The master modport is the CPU side, the slave is the responder.
interface z2_autoconfig_if;

  logic [23:0] A;
  logic        AS20;
  logic        DS20;
  logic        RW20;
  logic [3:0]  D_IN;
  logic [3:0]  D_OUT;
  logic        D_OE;
  logic        DTACK;
  logic        CONFIGURED;
  logic [3:0]  BASE;
  logic        Z2_ACCESS;

  modport master (
    output A, AS20, DS20, RW20, D_IN,
    input  D_OUT, D_OE, DTACK, CONFIGURED, BASE, Z2_ACCESS
  );

  modport slave (
    input  A, AS20, DS20, RW20, D_IN,
    output D_OUT, D_OE, DTACK, CONFIGURED, BASE, Z2_ACCESS
  );

endinterface

// File: rtl/z2_cfg_rom.sv
// Nibble-serial AutoConfig identity ROM. Maps the byte offset A[6:0] to the
// nibble presented on D[7:4]. The type register is read as-is; every other
// register is returned inverted, and unused offsets read 4'hF.
module z2_cfg_rom
  import tf328_pkg::*;
#(
  parameter logic [15:0] MANUF_ID   = 16'h082C,
  parameter logic [7:0]  PRODUCT_ID = 8'h01,
  parameter logic [31:0] SERIAL_NO  = 32'h0000_0000,
  parameter int          SIZE_MB    = 4
) (
  input  logic [6:0] offset,
  output logic [3:0] nibble
);

  // Type: Zorro II board, added to the free memory list, no boot ROM, no chaining
  localparam logic [7:0] TYPE_BYTE  = {2'b11, 1'b1, 1'b0, 1'b0, size_code(SIZE_MB)};
  localparam logic [7:0] FLAGS_BYTE = 8'h00;

  // Offset decode; anything not listed is an unused register and reads 4'hF
  always_comb begin
    nibble = 4'hF;
    case (offset)
      REG_TYPE:            nibble = TYPE_BYTE[7:4];
      REG_TYPE + 7'd2:     nibble = TYPE_BYTE[3:0];
      REG_PROD:            nibble = ~PRODUCT_ID[7:4];
      REG_PROD + 7'd2:     nibble = ~PRODUCT_ID[3:0];
      REG_FLAGS:           nibble = ~FLAGS_BYTE[7:4];
      REG_FLAGS + 7'd2:    nibble = ~FLAGS_BYTE[3:0];
      REG_MANUF:           nibble = ~MANUF_ID[15:12];
      REG_MANUF + 7'd2:    nibble = ~MANUF_ID[11:8];
      REG_MANUF + 7'd4:    nibble = ~MANUF_ID[7:4];
      REG_MANUF + 7'd6:    nibble = ~MANUF_ID[3:0];
      REG_SERIAL:          nibble = ~SERIAL_NO[31:28];
      REG_SERIAL + 7'd2:   nibble = ~SERIAL_NO[27:24];
      REG_SERIAL + 7'd4:   nibble = ~SERIAL_NO[23:20];
      REG_SERIAL + 7'd6:   nibble = ~SERIAL_NO[19:16];
      REG_SERIAL + 7'd8:   nibble = ~SERIAL_NO[15:12];
      REG_SERIAL + 7'd10:  nibble = ~SERIAL_NO[11:8];
      REG_SERIAL + 7'd12:  nibble = ~SERIAL_NO[7:4];
      REG_SERIAL + 7'd14:  nibble = ~SERIAL_NO[3:0];
      default:             nibble = 4'hF;
    endcase
  end

endmodule

// File: rtl/z2_autoconfig.sv
// Zorro II AutoConfig responder for the TF328 fast RAM.
// Answers the $E80000 probe while unconfigured, latches the base address
// written to $48 and then decodes the active-low RAM window match.
// Optional build macro: Z2_SHUTUP_EN -- a write to $4C parks the board in
// SHUTUP (no responses, no RAM window) until reset. Without it, $4C writes
// are acknowledged and ignored.
module z2_autoconfig
  import tf328_pkg::*;
#(
  parameter logic [15:0] MANUF_ID   = 16'h082C,
  parameter logic [7:0]  PRODUCT_ID = 8'h01,
  parameter logic [31:0] SERIAL_NO  = 32'h0000_0000,
  parameter int          SIZE_MB    = 4
) (
  input  logic CLKCPU,
  input  logic RESET,
  z2_autoconfig_if.slave bus
);

  cfg_state_t cfg_state;
  cyc_state_t cyc_state;
  logic [3:0] base_q;
  logic [3:0] d_out_q;
  logic       d_oe_q;
  logic       dtack_q;
  logic       cfg_pend;
`ifdef Z2_SHUTUP_EN
  logic       shut_pend;
`endif
  logic [6:0] offset;
  logic [3:0] rom_nibble;
  logic [3:0] diff;
  logic       cfg_sel;
  logic       wr_strobe;

  assign offset    = bus.A[6:0];
  assign cfg_sel   = ~bus.AS20 & (bus.A[23:16] == 8'hE8) & (cfg_state == UNCFG);
  assign wr_strobe = ~bus.AS20 & ~bus.DS20 & ~bus.RW20;
  assign diff      = bus.A[23:20] - base_q;

  z2_cfg_rom #(
    .MANUF_ID  (MANUF_ID),
    .PRODUCT_ID(PRODUCT_ID),
    .SERIAL_NO (SERIAL_NO),
    .SIZE_MB   (SIZE_MB)
  ) u_rom (
    .offset(offset),
    .nibble(rom_nibble)
  );

  // Bus cycle sequencing plus the configuration state; config changes wait
  // for the end of the cycle so the current access still gets its DTACK.
  // The low base nibble at $4A is acknowledged but nothing consumes it.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      cyc_state <= IDLE;
      cfg_state <= UNCFG;
      base_q    <= 4'h0;
      d_out_q   <= 4'hF;
      d_oe_q    <= 1'b0;
      dtack_q   <= 1'b1;
      cfg_pend  <= 1'b0;
`ifdef Z2_SHUTUP_EN
      shut_pend <= 1'b0;
`endif
    end else begin
      case (cyc_state)
        IDLE: begin
          if (cfg_sel) begin
            cyc_state <= WAIT;
            d_oe_q    <= bus.RW20;
            d_out_q   <= rom_nibble;
          end
        end
        WAIT: begin
          if (bus.AS20) begin
            cyc_state <= IDLE;
            d_oe_q    <= 1'b0;
            d_out_q   <= 4'hF;
          end else begin
            cyc_state <= ACK;
            dtack_q   <= 1'b0;
            d_out_q   <= rom_nibble;
          end
        end
        ACK: begin
          if (bus.AS20) begin
            cyc_state <= IDLE;
            dtack_q   <= 1'b1;
            d_oe_q    <= 1'b0;
            d_out_q   <= 4'hF;
            if (cfg_pend) begin
              cfg_state <= CONFIGURED;
              cfg_pend  <= 1'b0;
            end
`ifdef Z2_SHUTUP_EN
            if (shut_pend) begin
              cfg_state <= SHUTUP;
              shut_pend <= 1'b0;
            end
`endif
          end
        end
        default: cyc_state <= IDLE;
      endcase

      if ((cyc_state != IDLE) && wr_strobe) begin
        if (offset == REG_BASE_HI) begin
          base_q   <= bus.D_IN;
          cfg_pend <= 1'b1;
        end
`ifdef Z2_SHUTUP_EN
        if (offset == REG_SHUTUP) begin
          shut_pend <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.D_OUT      = d_out_q;
  assign bus.D_OE       = d_oe_q;
  assign bus.DTACK      = dtack_q;
  assign bus.CONFIGURED = (cfg_state == CONFIGURED);
  assign bus.BASE       = base_q;
  assign bus.Z2_ACCESS  = ~((cfg_state == CONFIGURED) & ~bus.AS20 &
                            (diff < 4'(SIZE_MB)));

endmodule
